// File: rtl/apb_fifo_pkg.sv
// Shared constants and the transfer FSM state type for the APB FIFO completer.
package apb_fifo_pkg;

  localparam int PADDR_SIZE_DEF = 4;
  localparam int PDATA_SIZE_DEF = 8;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_LEVEL  = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_THR_LSB   = 4;
  localparam int CTRL_THR_MSB   = 7;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_UDF_BIT   = 3;
  localparam int STAT_IRQ_BIT   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_fifo_slave_if.sv
// APB3/APB4 signal bundle between a requester (master) and the FIFO completer (slave).
interface apb_fifo_slave_if #(
  parameter int PADDR_SIZE = apb_fifo_pkg::PADDR_SIZE_DEF,
  parameter int PDATA_SIZE = apb_fifo_pkg::PDATA_SIZE_DEF
);
  logic                    PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_slave_sync_fifo.sv
// DEPTH x 8 synchronous FIFO with push/pop/flush; head byte is read combinationally.
module sync_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full
);
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer with CTRL/STATUS/DATA/LEVEL registers feeding a byte FIFO stream.
// Define APB_FIFO_SLVERR_EN to drive PSLVERR; otherwise it is tied low.
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int PADDR_SIZE  = PADDR_SIZE_DEF,
  parameter int PDATA_SIZE  = PDATA_SIZE_DEF,
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_fifo_slave_if.slave apb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            irq,
  output apb_state_e      dbg_state
);
  localparam int LW = $clog2(DEPTH) + 1;

  apb_state_e state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       en_q, en_d;
  logic [3:0] thr_q, thr_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;
  logic       irq_q, irq_d;

  logic [PADDR_SIZE-1:0] paddr;
  logic [PDATA_SIZE-1:0] pwdata;
  logic                  strb;
  logic                  commit;
  logic                  addr_ok;

  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;

  logic       err;
  logic [7:0] rd_val;
  logic [7:0] ctrl_rd;
  logic [7:0] stat_rd;
  logic       ctrl_wr;
  logic       stat_wr;
  logic       data_push;
  logic       ovf_set;
  logic       udf_set;
  logic       unused_pwdata;

  assign paddr         = apb.PADDR;
  assign pwdata        = apb.PWDATA;
  assign strb          = |apb.PSTRB;
  assign addr_ok       = ((paddr >> 2) == '0);
  assign commit        = (state_q == ACCESS) && apb.PSEL && apb.PENABLE;
  assign unused_pwdata = ^pwdata[3:2];

  // Transfer FSM: setup in IDLE, WAIT_STATES cycles of PREADY low, one ACCESS cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          wait_cnt_d = 3'(WAIT_STATES);
          state_d    = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (!apb.PSEL) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
          if (wait_cnt_q <= 3'd1) state_d = ACCESS;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_rd                              = '0;
    ctrl_rd[CTRL_EN_BIT]                 = en_q;
    ctrl_rd[CTRL_THR_MSB:CTRL_THR_LSB]   = thr_q;
    stat_rd                              = '0;
    stat_rd[STAT_EMPTY_BIT]              = fifo_empty;
    stat_rd[STAT_FULL_BIT]               = fifo_full;
    stat_rd[STAT_OVF_BIT]                = ovf_q;
    stat_rd[STAT_UDF_BIT]                = udf_q;
    stat_rd[STAT_IRQ_BIT]                = irq_q;
  end

  // Decode is evaluated every cycle but only acted on when commit is high.
  always_comb begin
    err       = 1'b0;
    rd_val    = '0;
    ctrl_wr   = 1'b0;
    stat_wr   = 1'b0;
    data_push = 1'b0;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (!addr_ok) begin
      err = 1'b1;
    end else begin
      case (paddr[1:0])
        ADDR_CTRL: begin
          if (apb.PWRITE) ctrl_wr = strb;
          else            rd_val  = ctrl_rd;
        end
        ADDR_STATUS: begin
          if (apb.PWRITE) stat_wr = strb;
          else            rd_val  = stat_rd;
        end
        ADDR_DATA: begin
          if (apb.PWRITE) begin
            if (strb && fifo_full) begin
              err     = 1'b1;
              ovf_set = 1'b1;
            end else begin
              data_push = strb;
            end
          end else if (fifo_empty) begin
            err     = 1'b1;
            udf_set = 1'b1;
          end else begin
            rd_val = fifo_head;
          end
        end
        default: begin
          if (apb.PWRITE) err    = strb;
          else            rd_val = 8'(fifo_level);
        end
      endcase
    end
  end

  always_comb begin
    en_d  = en_q;
    thr_d = thr_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    irq_d = en_q && (8'(fifo_level) < 8'(thr_q));
    if (commit) begin
      if (ctrl_wr) begin
        en_d  = pwdata[CTRL_EN_BIT];
        thr_d = pwdata[CTRL_THR_MSB:CTRL_THR_LSB];
      end
      if (stat_wr) begin
        if (pwdata[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (pwdata[STAT_UDF_BIT]) udf_d = 1'b0;
      end
      if (ovf_set) ovf_d = 1'b1;
      if (udf_set) udf_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      en_q       <= 1'b0;
      thr_q      <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      en_q       <= en_d;
      thr_q      <= thr_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      irq_q      <= irq_d;
    end
  end

  // Downstream stream: a byte moves on every cycle where out_valid && out_ready;
  // out_valid never depends on out_ready and out_data is stable while valid and not taken.
  assign out_valid  = en_q && !fifo_empty;
  assign out_data   = fifo_head;
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = commit && data_push;
  assign fifo_flush = commit && ctrl_wr && pwdata[CTRL_FLUSH_BIT];

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (pwdata[7:0]),
    .rdata (fifo_head),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign apb.PREADY = commit;
  assign apb.PRDATA = (commit && !apb.PWRITE && !err) ? PDATA_SIZE'(rd_val) : '0;
`ifdef APB_FIFO_SLVERR_EN
  assign apb.PSLVERR = commit && err;
`else
  assign apb.PSLVERR = 1'b0;
`endif

  assign irq       = irq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed plus randomized bench for apb_fifo_slave against a queue-based register/FIFO model.
module tb_apb_fifo_slave;
  import apb_fifo_pkg::*;

  localparam int WS    = 2;
  localparam int DEPTH = 8;
`ifdef APB_FIFO_SLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       irq;
  apb_state_e dbg_state;

  apb_fifo_slave_if #(.PADDR_SIZE(4), .PDATA_SIZE(8)) bus ();

  apb_fifo_slave #(
    .PADDR_SIZE  (4),
    .PDATA_SIZE  (8),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .PCLK      (clk),
    .PRESET    (rst),
    .apb       (bus.slave),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: FIFO contents as a queue plus register fields
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit         m_en;
  logic [3:0] m_thr;
  bit         m_ovf;
  bit         m_udf;
  bit         m_irq;
  bit         rnd_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One register access applied to the model; returns expected PRDATA/error.
  task automatic model_access(input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                              input bit strb, input bit pop,
                              output logic [7:0] rd, output bit err);
    bit push;
    bit flush;
    int sz;
    push  = 0;
    flush = 0;
    rd    = 8'h00;
    err   = 0;
    sz    = exp_q.size();
    if (addr > 4'd3) begin
      err = 1;
    end else if (!wr) begin
      case (addr)
        4'd0: rd = {m_thr, 3'b000, m_en};
        4'd1: rd = {3'b000, m_irq, m_udf, m_ovf, sz == DEPTH, sz == 0};
        4'd2: begin
          if (sz == 0) begin err = 1; m_udf = 1; end
          else rd = exp_q[0];
        end
        default: rd = 8'(sz);
      endcase
    end else if (strb) begin
      case (addr)
        4'd0: begin m_en = wd[0]; m_thr = wd[7:4]; flush = wd[1]; end
        4'd1: begin
          if (wd[2]) m_ovf = 0;
          if (wd[3]) m_udf = 0;
        end
        4'd2: begin
          if (sz == DEPTH) begin err = 1; m_ovf = 1; end
          else push = 1;
        end
        default: err = 1;
      endcase
    end
    if (err) rd = 8'h00;
    if (flush) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(wd);
    end
  endtask

  // Called #1 after a negedge with this cycle's inputs applied; ends on the next negedge.
  task automatic tick(input bit acc, input bit wr, input logic [3:0] addr,
                      input logic [7:0] wd, input bit strb);
    bit         exp_valid;
    bit         pop;
    bit         irq_n;
    logic [7:0] exp_rd;
    bit         exp_err;
    exp_valid = m_en && (exp_q.size() != 0);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) check("out_data", out_data, exp_q[0]);
    check("irq", irq, m_irq);
    check("pready", bus.PREADY, acc);
    if (out_valid && out_ready) obs_q.push_back(out_data);
    pop     = exp_valid && out_ready;
    irq_n   = m_en && (exp_q.size() < int'(m_thr));
    exp_rd  = 8'h00;
    exp_err = 0;
    if (acc) model_access(wr, addr, wd, strb, pop, exp_rd, exp_err);
    else if (pop) void'(exp_q.pop_front());
    check("prdata", bus.PRDATA, exp_rd);
    check("pslverr", bus.PSLVERR, exp_err && ERR_EN);
    m_irq = irq_n;
    @(negedge clk);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // driver tasks
  task automatic apb(input bit wr, input logic [3:0] addr, input logic [7:0] wd, input bit strb,
                     output logic [7:0] rd, output logic err);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wd;
    bus.PSTRB   = strb;
    #1;
    tick(0, 0, 4'd0, 8'd0, 0);
    bus.PENABLE = 1'b1;
    for (int i = 0; i < WS; i++) begin
      #1;
      tick(0, 0, 4'd0, 8'd0, 0);
    end
    #1;
    rd  = bus.PRDATA;
    err = bus.PSLVERR;
    tick(1, wr, addr, wd, strb);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) begin
      #1;
      tick(0, 0, 4'd0, 8'd0, 0);
    end
  endtask

  logic [7:0] rd;
  logic       er;

  initial begin
    rst         = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    out_ready   = 1'b0;
    rnd_ready   = 0;
    m_en        = 0;
    m_thr       = '0;
    m_ovf       = 0;
    m_udf       = 0;
    m_irq       = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_prdata", bus.PRDATA, 8'h00);
    check("rst_pready", bus.PREADY, 1'b0);
    check("rst_pslverr", bus.PSLVERR, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // register reset values
    apb(0, 4'h1, 8'h00, 1, rd, er);
    check("status_after_reset", rd, 8'h01);
    check("status_err", er, 1'b0);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_after_reset", rd, 8'h00);
    apb(0, 4'h0, 8'h00, 1, rd, er);
    check("ctrl_after_reset", rd, 8'h00);
    check("irq_after_reset", irq, 1'b0);

    // single push with downstream stalled, peek does not pop
    apb(1, 4'h2, 8'hA5, 1, rd, er);
    check("push_a5_err", er, 1'b0);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_one", rd, 8'h01);
    apb(0, 4'h2, 8'h00, 1, rd, er);
    check("peek_a5", rd, 8'hA5);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_still_one", rd, 8'h01);

    // flush, fill to full, overflow, W1C
    apb(1, 4'h0, 8'h02, 1, rd, er);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_after_flush", rd, 8'h00);
    for (int i = 0; i < DEPTH; i++) apb(1, 4'h2, 8'(8'h10 + i), 1, rd, er);
    apb(1, 4'h2, 8'h18, 1, rd, er);
    check("overflow_err", er, ERR_EN);
    apb(0, 4'h1, 8'h00, 1, rd, er);
    check("status_full_ovf", rd, 8'h06);
    apb(1, 4'h1, 8'h04, 1, rd, er);
    apb(0, 4'h1, 8'h00, 1, rd, er);
    check("status_ovf_cleared", rd, 8'h02);

    // enable with threshold 5 and drain
    out_ready = 1'b1;
    obs_q.delete();
    apb(1, 4'h0, 8'h51, 1, rd, er);
    idle(12);
    check("stream_count", obs_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++) check("stream_byte", obs_q[i], 8'h10 + i);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_drained", rd, 8'h00);

    // error responses
    apb(0, 4'h2, 8'h00, 1, rd, er);
    check("underflow_err", er, ERR_EN);
    check("underflow_prdata", rd, 8'h00);
    apb(0, 4'h1, 8'h00, 1, rd, er);
    check("status_udf_bit", rd[3], 1'b1);
    apb(0, 4'h7, 8'h00, 1, rd, er);
    check("bad_addr_err", er, ERR_EN);
    apb(1, 4'h3, 8'h55, 1, rd, er);
    check("level_write_err", er, ERR_EN);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_unchanged", rd, 8'h00);

    // PSEL dropped during wait states: no push
    apb(1, 4'h0, 8'h00, 1, rd, er);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 4'h2; bus.PWDATA = 8'h77; bus.PSTRB = 1'b1;
    #1; tick(0, 0, 4'd0, 8'd0, 0);
    bus.PENABLE = 1'b1;
    #1; tick(0, 0, 4'd0, 8'd0, 0);
    idle(2);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("abort_no_push", rd, 8'h00);

    // flush while downstream ready
    for (int i = 0; i < 4; i++) apb(1, 4'h2, 8'(8'h31 + i), 1, rd, er);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("level_four", rd, 8'h04);
    obs_q.delete();
    apb(1, 4'h0, 8'h03, 1, rd, er);
    #1;
    check("flush_out_valid", out_valid, 1'b0);
    tick(0, 0, 4'd0, 8'd0, 0);
    apb(0, 4'h3, 8'h00, 1, rd, er);
    check("flush_level", rd, 8'h00);
    idle(2);
    check("flush_no_pop", obs_q.size(), 0);

    // randomized traffic against the model
    rnd_ready = 1;
    for (int t = 0; t < 120; t++) begin
      logic [3:0] a;
      logic [7:0] d;
      bit         w;
      bit         s;
      int         r;
      r = $urandom_range(0, 11);
      if (r == 0)      a = 4'($urandom_range(4, 15));
      else if (r <= 5) a = 4'h2;
      else if (r <= 7) a = 4'h0;
      else if (r <= 9) a = 4'h1;
      else             a = 4'h3;
      w = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      if (a == 4'h0 && $urandom_range(0, 5) != 0) d[1] = 1'b0;
      apb(w, a, d, s, rd, er);
      r = $urandom_range(0, 2);
      if (r > 0) idle(r);
    end
    rnd_ready = 0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
